// File: rtl/spi_master_rx_gen_pkg.sv
// Shared definitions for the SPI master receive shifter: FSM state encoding,
// lane-mode encoding, reset bit target and the lane-count helper.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        RECEIVE        = 2'd1,
        WAIT_FIFO      = 2'd2,
        WAIT_FIFO_DONE = 2'd3
    } rx_state_t;

    localparam logic [1:0] LANE_SINGLE = 2'b00;
    localparam logic [1:0] LANE_DUAL   = 2'b01;
    localparam logic [1:0] LANE_QUAD   = 2'b10;

    localparam int RX_RST_TRGT = 8;

    // log2 of the lane count; the reserved encoding behaves as single lane
    function automatic logic [1:0] lane_shift(input logic [1:0] mode);
        case (mode)
            LANE_DUAL: lane_shift = 2'd1;
            LANE_QUAD: lane_shift = 2'd2;
            default:   lane_shift = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_master_rx_gen_if.sv
// Word handshake between the receive shifter and the RX FIFO.
interface spi_master_rx_gen_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]        data;
    logic [$clog2(DATA_W):0]  data_bits;
    logic                     data_valid;
    logic                     data_ready;

    modport master (output data, data_bits, data_valid, input data_ready);
    modport slave  (input data, data_bits, data_valid, output data_ready);
endinterface

// File: rtl/spi_master_rx_gen_shreg.sv
// Lane-select, direction-aware shift register. The word output is the value
// the register would hold after the current shift, right-justified when the
// word is a partial LSB-first one.
module spi_rx_shreg
    import spi_rx_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr,
    input  logic                      shift,
    input  logic [1:0]                mode,
    input  logic                      lsb_first,
    input  logic [$clog2(DATA_W):0]   word_bits,
    input  logic [3:0]                sdi,
    output logic [DATA_W-1:0]         word
);
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] FULL = BW'(DATA_W);

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;

    // next shift value and justified word for the current beat
    always_comb begin
        shreg_nxt = shreg;
        case (mode)
            LANE_DUAL: shreg_nxt = lsb_first ? {sdi[1:0], shreg[DATA_W-1:2]}
                                             : {shreg[DATA_W-3:0], sdi[1:0]};
            LANE_QUAD: shreg_nxt = lsb_first ? {sdi[3:0], shreg[DATA_W-1:4]}
                                             : {shreg[DATA_W-5:0], sdi[3:0]};
            default:   shreg_nxt = lsb_first ? {sdi[1], shreg[DATA_W-1:1]}
                                             : {shreg[DATA_W-2:0], sdi[1]};
        endcase
        word = shreg_nxt;
        if (lsb_first && (word_bits < FULL))
            word = shreg_nxt >> (FULL - word_bits);
    end

    // shift register; cleared at transfer start and after every word so a
    // partial MSB-first tail has zero upper bits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            shreg <= '0;
        else if (clr)
            shreg <= '0;
        else if (shift)
            shreg <= shreg_nxt;
    end

endmodule

// File: rtl/spi_master_rx_gen.sv
// SPI master receive shifter: collects 1/2/4-lane SDI beats into words,
// hands them to the RX FIFO and stalls the SPI clock while a word waits.
// Optional build macro SPI_RX_STALL_CNT_EN adds the stall_cnt output.
module spi_master_rx_gen
    import spi_rx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               rx_edge,
    input  logic [3:0]         sdi,
    input  logic [1:0]         lane_mode,
    input  logic               lsb_first,
    input  logic [CNT_W-1:0]   counter_in,
    input  logic               counter_in_upd,
    output logic               rx_done,
    output logic               clk_en_o,
`ifdef SPI_RX_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    spi_master_rx_gen_if.master rx
);
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [BW-1:0] FULL = BW'(DATA_W);

    rx_state_t         state, state_nxt;
    logic [CNT_W-1:0]  trgt, tgt_beats, beat_cnt, beat_inc, eff_trgt, start_beats;
    logic [BW-1:0]     word_cnt, word_cnt_inc, word_bits;
    logic [1:0]        mode_q;
    logic              lsb_q;
    logic              edge_rx, last_beat, word_full, complete, accept;
    logic              start, zero_start, done_set;
    logic [DATA_W-1:0] word, data_q;
    logic [BW-1:0]     data_bits_q;
    logic              data_valid_q;

    assign rx.data       = data_q;
    assign rx.data_bits  = data_bits_q;
    assign rx.data_valid = data_valid_q;

    assign eff_trgt     = counter_in_upd ? counter_in : trgt;
    assign start_beats  = eff_trgt >> lane_shift(lane_mode);
    assign edge_rx      = (state == RECEIVE) && rx_edge;
    assign beat_inc     = beat_cnt + 1'b1;
    assign word_cnt_inc = word_cnt + 1'b1;
    assign word_bits    = word_cnt_inc << lane_shift(mode_q);
    assign last_beat    = (beat_inc == tgt_beats);
    assign word_full    = (word_cnt_inc == (FULL >> lane_shift(mode_q)));
    assign complete     = edge_rx && (word_full || last_beat);
    assign accept       = data_valid_q && rx.data_ready;

    spi_rx_shreg #(.DATA_W(DATA_W)) u_shreg (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (start || complete),
        .shift     (edge_rx),
        .mode      (mode_q),
        .lsb_first (lsb_q),
        .word_bits (word_bits),
        .sdi       (sdi),
        .word      (word)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decode, SPI clock enable and transfer start/done strobes
    always_comb begin
        state_nxt  = state;
        clk_en_o   = 1'b0;
        start      = 1'b0;
        zero_start = 1'b0;
        done_set   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    if (start_beats != '0) begin
                        start     = 1'b1;
                        state_nxt = RECEIVE;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            RECEIVE: begin
                clk_en_o = 1'b1;
                if (complete) state_nxt = last_beat ? WAIT_FIFO_DONE : WAIT_FIFO;
            end
            WAIT_FIFO: begin
                if (accept) state_nxt = RECEIVE;
            end
            WAIT_FIFO_DONE: begin
                if (accept) begin
                    state_nxt = IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // target, beat counters, transfer configuration and output word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trgt         <= CNT_W'(RX_RST_TRGT);
            tgt_beats    <= '0;
            beat_cnt     <= '0;
            word_cnt     <= '0;
            mode_q       <= LANE_SINGLE;
            lsb_q        <= 1'b0;
            data_q       <= '0;
            data_bits_q  <= '0;
            data_valid_q <= 1'b0;
            rx_done      <= 1'b0;
        end else begin
            rx_done <= zero_start || done_set;
            if ((state == IDLE) && counter_in_upd)
                trgt <= counter_in;
            if (start) begin
                tgt_beats <= start_beats;
                beat_cnt  <= '0;
                word_cnt  <= '0;
                mode_q    <= lane_mode;
                lsb_q     <= lsb_first;
            end else if (edge_rx) begin
                beat_cnt <= beat_inc;
                word_cnt <= complete ? '0 : word_cnt_inc;
            end
            if (complete) begin
                data_q       <= word;
                data_bits_q  <= word_bits;
                data_valid_q <= 1'b1;
            end else if (accept) begin
                data_valid_q <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_STALL_CNT_EN
    // saturating count of cycles a finished word waits on the FIFO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (start)
            stall_cnt <= '0;
        else if (((state == WAIT_FIFO) || (state == WAIT_FIFO_DONE)) &&
                 !rx.data_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_spi_master_rx_gen.sv
// Directed testbench for spi_master_rx_gen (DATA_W=32, CNT_W=16).
module tb_spi_master_rx_gen;
    import spi_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        rx_edge = 1'b0;
    logic [3:0]  sdi = 4'h0;
    logic [1:0]  lane_mode = LANE_SINGLE;
    logic        lsb_first = 1'b0;
    logic [15:0] counter_in = 16'd0;
    logic        counter_in_upd = 1'b0;
    logic        rx_done;
    logic        clk_en_o;
`ifdef SPI_RX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    spi_master_rx_gen_if #(.DATA_W(32)) rx_if ();

    spi_master_rx_gen #(.DATA_W(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .rx_edge        (rx_edge),
        .sdi            (sdi),
        .lane_mode      (lane_mode),
        .lsb_first      (lsb_first),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .rx_done        (rx_done),
        .clk_en_o       (clk_en_o),
`ifdef SPI_RX_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .rx             (rx_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [3:0]  beats [0:63];
    int          waits [0:63];
    logic [31:0] word_q [$];
    logic [5:0]  bits_q [$];
    int cyc = 0, acc_cyc = -1, done_cyc = -1, done_cnt = 0;

    // capture accepted words and rx_done pulses using pre-edge values
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_if.data_valid && rx_if.data_ready) begin
            word_q.push_back(rx_if.data);
            bits_q.push_back(rx_if.data_bits);
            acc_cyc <= cyc;
        end
        if (rx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic start_xfer(input logic [15:0] cnt, input logic [1:0] mode, input logic lsb);
        @(negedge clk);
        counter_in = cnt; counter_in_upd = 1'b1; en = 1'b1;
        lane_mode = mode; lsb_first = lsb;
        @(negedge clk);
        counter_in_upd = 1'b0; en = 1'b0;
        lane_mode = 2'b11; lsb_first = ~lsb;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            rx_edge = 1'b0;
            while (!clk_en_o) begin
                if (w == 50) begin
                    checks++; failures++;
                    $display("FAIL feed_timeout beat=%0d clk_en_o stayed 0", i);
                    return;
                end
                @(negedge clk);
                w++;
            end
            waits[i] = w;
            sdi = beats[i];
            rx_edge = 1'b1;
            @(negedge clk);
        end
        rx_edge = 1'b0;
    endtask

    task automatic fill_single(input int base, input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++)
            beats[base+i] = {2'b10, w[nbits-1-i], ~w[nbits-1-i]};
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rx_if.data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", rx_if.data); end
        checks++; if (rx_if.data_bits !== 6'd0) begin failures++; $display("FAIL reset_bits got=%0d exp=0", rx_if.data_bits); end
        checks++; if (rx_if.data_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_if.data_valid); end
        checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", rx_done); end
        checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL reset_clk_en got=%b exp=0", clk_en_o); end
`ifdef SPI_RX_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
`endif
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_msb;
        int d0;
        word_q.delete(); bits_q.delete();
        rx_if.data_ready = 1'b1;
        d0 = done_cnt;
        fill_single(0, 32'hA5C3_0F1E, 32);
        start_xfer(16'd32, LANE_SINGLE, 1'b0);
        feed(32);
        repeat (4) @(negedge clk);
        checks++; if (word_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", word_q.size()); end
        else begin
            checks++; if (word_q[0] !== 32'hA5C3_0F1E) begin failures++; $display("FAIL single_data got=%h exp=a5c30f1e", word_q[0]); end
            checks++; if (bits_q[0] !== 6'd32) begin failures++; $display("FAIL single_bits got=%0d exp=32", bits_q[0]); end
        end
        checks++; if (done_cnt != d0 + 1) begin failures++; $display("FAIL single_done_cnt got=%0d exp=%0d", done_cnt, d0 + 1); end
        checks++; if (done_cyc != acc_cyc + 1) begin failures++; $display("FAIL single_done_lat got=%0d exp=%0d", done_cyc, acc_cyc + 1); end
    endtask

    task automatic test_quad;
        logic [63:0] v;
        word_q.delete(); bits_q.delete();
        rx_if.data_ready = 1'b1;
        v = 64'h1234_5678_9ABC_DEF0;
        for (int i = 0; i < 16; i++) beats[i] = v[63-4*i -: 4];
        start_xfer(16'd64, LANE_QUAD, 1'b0);
        feed(16);
        repeat (4) @(negedge clk);
        checks++; if (waits[8] != 1) begin failures++; $display("FAIL quad_gap got=%0d exp=1", waits[8]); end
        checks++; if (word_q.size() != 2) begin failures++; $display("FAIL quad_count got=%0d exp=2", word_q.size()); end
        else begin
            checks++; if (word_q[0] !== 32'h1234_5678) begin failures++; $display("FAIL quad_word0 got=%h exp=12345678", word_q[0]); end
            checks++; if (word_q[1] !== 32'h9ABC_DEF0) begin failures++; $display("FAIL quad_word1 got=%h exp=9abcdef0", word_q[1]); end
            checks++; if (bits_q[1] !== 6'd32) begin failures++; $display("FAIL quad_bits got=%0d exp=32", bits_q[1]); end
        end
    endtask

    task automatic test_dual_lsb_partial;
        logic [1:0] b [0:5];
        word_q.delete(); bits_q.delete();
        rx_if.data_ready = 1'b1;
        b[0] = 2'd1; b[1] = 2'd2; b[2] = 2'd3; b[3] = 2'd0; b[4] = 2'd1; b[5] = 2'd2;
        for (int i = 0; i < 6; i++) beats[i] = {2'b11, b[i]};
        start_xfer(16'd12, LANE_DUAL, 1'b1);
        feed(6);
        repeat (4) @(negedge clk);
        checks++; if (word_q.size() != 1) begin failures++; $display("FAIL dual_count got=%0d exp=1", word_q.size()); end
        else begin
            checks++; if (word_q[0] !== 32'h0000_0939) begin failures++; $display("FAIL dual_data got=%h exp=00000939", word_q[0]); end
            checks++; if (bits_q[0] !== 6'd12) begin failures++; $display("FAIL dual_bits got=%0d exp=12", bits_q[0]); end
        end
    endtask

    task automatic test_stall;
        word_q.delete(); bits_q.delete();
        rx_if.data_ready = 1'b0;
        fill_single(0, 32'hDEAD_BEEF, 32);
        start_xfer(16'd64, LANE_SINGLE, 1'b0);
        feed(32);
        for (int i = 0; i < 10; i++) begin
            checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL stall_clk_en cyc=%0d got=%b exp=0", i, clk_en_o); end
            checks++; if (rx_if.data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_data cyc=%0d got=%h exp=deadbeef", i, rx_if.data); end
            checks++; if (rx_if.data_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, rx_if.data_valid); end
            sdi = 4'hF; rx_edge = 1'b1;
            @(negedge clk);
        end
        rx_edge = 1'b0;
`ifdef SPI_RX_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd10) begin failures++; $display("FAIL stall_cnt got=%0d exp=10", stall_cnt); end
`endif
        rx_if.data_ready = 1'b1;
        fill_single(0, 32'h1357_9BDF, 32);
        feed(32);
        repeat (4) @(negedge clk);
        checks++; if (word_q.size() != 2) begin failures++; $display("FAIL stall_count got=%0d exp=2", word_q.size()); end
        else begin
            checks++; if (word_q[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_word0 got=%h exp=deadbeef", word_q[0]); end
            checks++; if (word_q[1] !== 32'h1357_9BDF) begin failures++; $display("FAIL stall_word1 got=%h exp=13579bdf", word_q[1]); end
        end
    endtask

    task automatic test_zero_length;
        int d0;
        word_q.delete(); bits_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        counter_in = 16'd0; counter_in_upd = 1'b1; lane_mode = LANE_SINGLE;
        @(negedge clk);
        counter_in_upd = 1'b0; counter_in = 16'd32; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        checks++; if (rx_done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", rx_done); end
        checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL zero_clk_en got=%b exp=0", clk_en_o); end
        @(negedge clk);
        checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", rx_done); end
        repeat (3) @(negedge clk);
        checks++; if (word_q.size() != 0) begin failures++; $display("FAIL zero_words got=%0d exp=0", word_q.size()); end
        checks++; if (done_cnt != d0 + 1) begin failures++; $display("FAIL zero_done_cnt got=%0d exp=%0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_reset_mid;
        word_q.delete(); bits_q.delete();
        rx_if.data_ready = 1'b1;
        fill_single(0, 32'hFFFF_FFFF, 32);
        start_xfer(16'd32, LANE_SINGLE, 1'b0);
        feed(5);
        rstn = 1'b0;
        #1;
        checks++; if (rx_if.data !== 32'd0) begin failures++; $display("FAIL mid_reset_data got=%h exp=0", rx_if.data); end
        checks++; if (rx_if.data_bits !== 6'd0) begin failures++; $display("FAIL mid_reset_bits got=%0d exp=0", rx_if.data_bits); end
        checks++; if (rx_if.data_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", rx_if.data_valid); end
        checks++; if (clk_en_o !== 1'b0) begin failures++; $display("FAIL mid_reset_clk_en got=%b exp=0", clk_en_o); end
        checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=%b exp=0", rx_done); end
        @(negedge clk);
        rstn = 1'b1;
        fill_single(0, 32'h0000_00C6, 8);
        start_xfer(16'd8, LANE_SINGLE, 1'b0);
        feed(8);
        repeat (4) @(negedge clk);
        checks++; if (word_q.size() != 1) begin failures++; $display("FAIL mid_count got=%0d exp=1", word_q.size()); end
        else begin
            checks++; if (bits_q[0] !== 6'd8) begin failures++; $display("FAIL mid_bits got=%0d exp=8", bits_q[0]); end
            checks++; if (word_q[0] !== 32'h0000_00C6) begin failures++; $display("FAIL mid_data got=%h exp=000000c6", word_q[0]); end
        end
    endtask

    initial begin
        rx_if.data_ready = 1'b1;
        test_reset();
        test_single_msb();
        test_quad();
        test_dual_lsb_partial();
        test_stall();
        test_zero_length();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_rx_gen.md
Name: spi_master_rx_gen

Overview:
Parametrised SPI master receive shifter for the hbirdv2 APB SPI master. It supports single, dual and quad lanes, MSB- or LSB-first order, a configurable word width, and a partial last word with a valid-bit count. It sits between the SPI clock generator (rx_edge, clk_en_o) and the RX FIFO (valid/ready). It shifts sampled SDI lanes into words and stalls the SPI clock while the FIFO is not accepting.

Parameters:
DATA_W, 32, output word width in bits; a multiple of 4, at least 8.
CNT_W, 16, width of the transfer bit-count input.

Ports:
clk  in  1  clock
rstn  in  1  asynchronous, active-low reset
en  in  1  start request; sampled in IDLE only
rx_edge  in  1  sample strobe from the clock generator, one clk cycle wide
sdi  in  4  serial data lanes [3:0]
lane_mode  in  2  00 single (sdi[1]), 01 dual ({sdi[1],sdi[0]}), 10 quad (sdi[3:0]), 11 reserved, treated as single
lsb_first  in  1  0 = first received bit lands in the MSB; 1 = first received bit lands in bit 0
counter_in  in  CNT_W  transfer length in bits
counter_in_upd  in  1  load counter_in; honoured in IDLE only
data  out  DATA_W  received word, right-justified, upper bits zero when partial
data_bits  out  $clog2(DATA_W)+1  number of valid bits in data (1..DATA_W)
data_valid  out  1  word available
data_ready  in  1  FIFO accepts the word
rx_done  out  1  one-cycle pulse when the final word is accepted, or on a zero-length start
clk_en_o  out  1  SPI clock enable request

Behaviour:
- Reset values: data 0, data_bits 0, data_valid 0, rx_done 0, clk_en_o 0. Internal state: FSM IDLE, bit target 8, counters 0.
- Lane count L = 1, 2 or 4 from lane_mode. Beats per transfer = counter_in >> log2(L); low bits that are not a multiple of L are truncated. Beats per word = DATA_W / L.
- FSM states: IDLE, RECEIVE, WAIT_FIFO, WAIT_FIFO_DONE.
- IDLE:
  - clk_en_o = 0.
  - When en = 1 and target beats > 0, go to RECEIVE and clear the shift register and counters.
  - When en = 1 and target beats = 0, pulse rx_done next cycle and stay in IDLE.
- RECEIVE:
  - clk_en_o = 1.
  - On each rx_edge, shift in L bits and increment both the beat counter and the word-beat counter.
  - MSB-first: shreg = {shreg[DATA_W-L-1:0], lanes}.
  - LSB-first: shreg = {lanes, shreg[DATA_W-1:L]}; lanes keep their internal order, sdi[0] lowest.
- Word completion (word-beat counter reaches DATA_W/L, or total beats reach target):
  - On the same edge, load data with the final shreg value, including the bits from this edge.
  - data_bits = word beats × L.
  - For a partial LSB-first word, right-shift by DATA_W − data_bits before loading.
  - Set data_valid (registered, visible the next cycle).
  - Go to WAIT_FIFO_DONE if it was the last beat, otherwise WAIT_FIFO. Reset the word-beat counter.
- WAIT_FIFO and WAIT_FIFO_DONE:
  - clk_en_o = 0; rx_edge is ignored.
  - data and data_bits are held stable while data_valid = 1.
  - On data_valid && data_ready, clear data_valid.
  - WAIT_FIFO then returns to RECEIVE.
  - WAIT_FIFO_DONE returns to IDLE and asserts rx_done for one cycle (registered).
- Latency: data_valid rises 1 cycle after the completing rx_edge. Minimum one idle clk cycle between words (no back-to-back acceptance).
- Ignored inputs:
  - counter_in_upd outside IDLE is ignored and the target is kept.
  - en outside IDLE is ignored.
  - lane_mode and lsb_first are sampled at the IDLE→RECEIVE transition and held for the whole transfer.
- Simultaneous counter_in_upd and en in IDLE: the new target is used for the transfer being started.
- Beat and total counters are CNT_W wide and never wrap within a legal transfer.
- rstn asserted mid-transfer: immediate return to IDLE with reset values; any pending word is discarded.

Optional Feature:
SPI_RX_STALL_CNT_EN:
- Defined: adds output stall_cnt [15:0].
  - Increments on every clk cycle spent in WAIT_FIFO or WAIT_FIFO_DONE with data_ready = 0.
  - Saturates at 16'hFFFF.
  - Cleared on the IDLE→RECEIVE transition and by reset.
- Undefined: the port and its logic are absent.

Decomposition:
- Package spi_rx_pkg holds:
  - FSM state encodings (IDLE = 0, RECEIVE = 1, WAIT_FIFO = 2, WAIT_FIFO_DONE = 3);
  - lane_mode encodings (LANE_SINGLE, LANE_DUAL, LANE_QUAD);
  - reset target constant RX_RST_TRGT = 8.
- One sub-module, spi_rx_shreg: the lane-select, direction-aware shift register plus the partial-word justification shifter. The FSM and counters stay in the top module.

Test Plan:
- Single lane, MSB-first, DATA_W=32, counter_in=32, sdi[1] bits = 0xA5C3_0F1E MSB-first, data_ready=1:
  - one data_valid with data=0xA5C30F1E and data_bits=32;
  - rx_done pulse one cycle after acceptance.
- Quad lane, counter_in=64, nibbles 0x12345678 then 0x9ABCDEF0 → two words in order; clk_en_o low for exactly one cycle between them.
- Dual lane, LSB-first, counter_in=12 → data_bits=12, data holds the 12 bits right-justified, upper 20 bits zero.
- data_ready held 0 for 10 cycles after the first word of a 64-bit single-lane transfer:
  - clk_en_o=0 and data stable throughout;
  - stall_cnt=10 when SPI_RX_STALL_CNT_EN is defined;
  - transfer resumes after ready.
- counter_in_upd with counter_in=0, then en → no data_valid; rx_done pulses once next cycle.
- rstn asserted after 5 rx_edges of a 32-bit transfer → all outputs return to reset values; the next en with counter_in=8 produces data_bits=8.
